// File: rtl/toothless_pkg.sv
// Shared constants and types for the toothless core front end.
// Optional build macro TOOTHLESS_MISALIGN_TRAP_EN is consumed by pc_next_calc.
package toothless_pkg;

    localparam logic [1:0] CTRL_TRANS_SEL_NONE   = 2'b00;
    localparam logic [1:0] CTRL_TRANS_SEL_JUMP   = 2'b01;
    localparam logic [1:0] CTRL_TRANS_SEL_BRANCH = 2'b10;

    typedef enum logic [1:0] {
        PC_BOOT = 2'b00,
        PC_RUN  = 2'b01,
        PC_HALT = 2'b10
    } pc_state_e;

    // Start of .text and trap vector for the default 32-bit build.
    localparam logic [31:0] PC_RESET_ADDR_DEF  = 32'h0001_0074;
    localparam logic [31:0] PC_TRAP_VEC_DEF    = 32'h0000_0100;
    localparam int          PC_INSTR_BYTES_DEF = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-port handshake between pc_gen (master) and the instruction-memory fetch unit (slave).
// The fetch side asserts fetch_ready_i when it accepts pc_o in the same cycle.
interface pc_gen_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] pc_o;
    logic                  pc_valid_o;
    logic [ADDR_WIDTH-1:0] pc_plus4_o;
    logic                  fetch_ready_i;

    modport master (
        output pc_o,
        output pc_valid_o,
        output pc_plus4_o,
        input  fetch_ready_i
    );

    modport slave (
        input  pc_o,
        input  pc_valid_o,
        input  pc_plus4_o,
        output fetch_ready_i
    );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC/next-EPC selection: trap > mret > hold > jump > taken branch > sequential.
// TOOTHLESS_MISALIGN_TRAP_EN turns a misaligned redirect into a trap instead of truncating it.
module pc_next_calc
    import toothless_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VEC    = ADDR_WIDTH'(PC_TRAP_VEC_DEF),
    parameter int                    INSTR_BYTES = PC_INSTR_BYTES_DEF
) (
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [ADDR_WIDTH-1:0] epc_i,
    input  logic [1:0]            ctrl_trans_instr_i,
    input  logic [ADDR_WIDTH-1:0] offset_i,
    input  logic                  branch_tkn_i,
    input  logic [ADDR_WIDTH-1:0] tgt_addr_i,
    input  logic                  adv_i,
    input  logic                  trap_i,
    input  logic                  mret_i,
    output logic [ADDR_WIDTH-1:0] next_pc_o,
    output logic [ADDR_WIDTH-1:0] next_epc_o,
    output logic                  misaligned_o
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] target;
    logic                  target_mis;

    always_comb begin
        redirect = 1'b0;
        target   = tgt_addr_i;
        case (ctrl_trans_instr_i)
            CTRL_TRANS_SEL_JUMP: begin
                redirect = 1'b1;
                target   = tgt_addr_i;
            end
            CTRL_TRANS_SEL_BRANCH: begin
                redirect = branch_tkn_i;
                target   = pc_i + offset_i;
            end
            default: begin
                redirect = 1'b0;
                target   = tgt_addr_i;
            end
        endcase
        target_mis = |(target & ALIGN_MASK);
    end

    always_comb begin
        next_pc_o    = pc_i;
        next_epc_o   = epc_i;
        misaligned_o = 1'b0;
        if (trap_i) begin
            next_pc_o  = TRAP_VEC;
            next_epc_o = pc_i;
        end else if (mret_i) begin
            next_pc_o = epc_i;
        end else if (adv_i) begin
            if (redirect && target_mis) begin
                misaligned_o = 1'b1;
`ifdef TOOTHLESS_MISALIGN_TRAP_EN
                next_pc_o  = TRAP_VEC;
                next_epc_o = target;
`else
                next_pc_o  = target & ~ALIGN_MASK;
`endif
            end else if (redirect) begin
                next_pc_o = target;
            end else begin
                next_pc_o = pc_i + ADDR_WIDTH'(INSTR_BYTES);
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit: BOOT/RUN/HALT sequencing, PC, EPC and misalignment pulse registers.
// Build with TOOTHLESS_MISALIGN_TRAP_EN to trap on misaligned redirects (default: truncate).
module pc_gen
    import toothless_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = ADDR_WIDTH'(PC_RESET_ADDR_DEF),
    parameter logic [ADDR_WIDTH-1:0] TRAP_VEC    = ADDR_WIDTH'(PC_TRAP_VEC_DEF),
    parameter int                    INSTR_BYTES = PC_INSTR_BYTES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_gen_if.master              fetch,
    input  logic [1:0]            ctrl_trans_instr_i,
    input  logic [ADDR_WIDTH-1:0] offset_i,
    input  logic                  branch_tkn_i,
    input  logic [ADDR_WIDTH-1:0] tgt_addr_i,
    input  logic                  stall_i,
    input  logic                  trap_i,
    input  logic                  mret_i,
    input  logic                  halt_i,
    input  logic                  resume_i,
    output logic [ADDR_WIDTH-1:0] epc_o,
    output logic                  misaligned_o,
    output logic                  halted_o
);

    pc_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    logic                  mis_q, mis_d;

    logic [ADDR_WIDTH-1:0] calc_pc, calc_epc;
    logic                  calc_mis;
    logic                  adv;

    assign adv = !stall_i && fetch.fetch_ready_i;

    pc_next_calc #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .TRAP_VEC    (TRAP_VEC),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next (
        .pc_i               (pc_q),
        .epc_i              (epc_q),
        .ctrl_trans_instr_i (ctrl_trans_instr_i),
        .offset_i           (offset_i),
        .branch_tkn_i       (branch_tkn_i),
        .tgt_addr_i         (tgt_addr_i),
        .adv_i              (adv),
        .trap_i             (trap_i),
        .mret_i             (mret_i),
        .next_pc_o          (calc_pc),
        .next_epc_o         (calc_epc),
        .misaligned_o       (calc_mis)
    );

    // PC/EPC only move in RUN; BOOT and HALT (including the resume cycle) hold them.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        case (state_q)
            PC_BOOT: state_d = PC_RUN;
            PC_RUN: begin
                pc_d  = calc_pc;
                epc_d = calc_epc;
                mis_d = calc_mis;
                if (halt_i && !trap_i) begin
                    state_d = PC_HALT;
                end
            end
            PC_HALT: begin
                if (resume_i) begin
                    state_d = PC_RUN;
                end
            end
            default: state_d = PC_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PC_BOOT;
            pc_q    <= RESET_ADDR;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

    assign fetch.pc_o       = pc_q;
    assign fetch.pc_valid_o = (state_q == PC_RUN);
    assign fetch.pc_plus4_o = pc_q + ADDR_WIDTH'(INSTR_BYTES);
    assign epc_o            = epc_q;
    assign misaligned_o     = mis_q;
    assign halted_o         = (state_q == PC_HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboarded bench for pc_gen: each scenario queues expected outputs as it drives a cycle.
module tb_pc_gen;
    import toothless_pkg::*;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [31:0] off;
        logic        tkn;
        logic [31:0] tgt;
        logic        stall;
        logic        rdy;
        logic        trap;
        logic        mret;
        logic        halt;
        logic        resume;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        vld;
        logic [31:0] p4;
        logic [31:0] epc;
        logic        mis;
        logic        hlt;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ctrl_trans_instr;
    logic [31:0] offset;
    logic        branch_tkn;
    logic [31:0] tgt_addr;
    logic        stall;
    logic        trap;
    logic        mret;
    logic        halt;
    logic        resume;
    logic [31:0] epc;
    logic        misaligned;
    logic        halted;

    obs_t        exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] cur_epc;

    pc_gen_if #(.ADDR_WIDTH(32)) fif ();

    pc_gen dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch              (fif),
        .ctrl_trans_instr_i (ctrl_trans_instr),
        .offset_i           (offset),
        .branch_tkn_i       (branch_tkn),
        .tgt_addr_i         (tgt_addr),
        .stall_i            (stall),
        .trap_i             (trap),
        .mret_i             (mret),
        .halt_i             (halt),
        .resume_i           (resume),
        .epc_o              (epc),
        .misaligned_o       (misaligned),
        .halted_o           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t s_none();
        stim_t s;
        s      = '0;
        s.ctrl = CTRL_TRANS_SEL_NONE;
        s.rdy  = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_jump(input logic [31:0] t);
        stim_t s;
        s      = s_none();
        s.ctrl = CTRL_TRANS_SEL_JUMP;
        s.tgt  = t;
        return s;
    endfunction

    function automatic stim_t s_br(input logic [31:0] o, input logic k);
        stim_t s;
        s      = s_none();
        s.ctrl = CTRL_TRANS_SEL_BRANCH;
        s.off  = o;
        s.tkn  = k;
        return s;
    endfunction

    function automatic obs_t mk(input logic [31:0] p, input logic [31:0] e,
                                input logic v, input logic h, input logic m);
        obs_t o;
        o.pc  = p;
        o.vld = v;
        o.p4  = p + 32'd4;
        o.epc = e;
        o.mis = m;
        o.hlt = h;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pc  = fif.pc_o;
        o.vld = fif.pc_valid_o;
        o.p4  = fif.pc_plus4_o;
        o.epc = epc;
        o.mis = misaligned;
        o.hlt = halted;
        return o;
    endfunction

    task automatic apply(input stim_t s);
        ctrl_trans_instr  = s.ctrl;
        offset            = s.off;
        branch_tkn        = s.tkn;
        tgt_addr          = s.tgt;
        stall             = s.stall;
        fif.fetch_ready_i = s.rdy;
        trap              = s.trap;
        mret              = s.mret;
        halt              = s.halt;
        resume            = s.resume;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        obs_t  g, e;
        s      = s_none();
        s.trap = 1'b1;
        rst_n  = 1'b0;
        apply(s);
        exp_q.push_back(mk(32'h10074, 32'h0, 1'b0, 1'b0, 1'b0));
        apply(s);
        g = sample();
        e = exp_q.pop_front();
        n_assert++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL reset: got pc=%h vld=%b p4=%h epc=%h mis=%b hlt=%b, want pc=%h vld=%b p4=%h epc=%h mis=%b hlt=%b",
                     g.pc, g.vld, g.p4, g.epc, g.mis, g.hlt, e.pc, e.vld, e.p4, e.epc, e.mis, e.hlt);
        end
        rst_n = 1'b1;
    endtask

    task automatic run_steps(input string name, input stim_t st[$]);
        obs_t g, e;
        foreach (st[i]) begin
            apply(st[i]);
            g = sample();
            e = exp_q.pop_front();
            n_assert++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s[%0d]: got pc=%h vld=%b p4=%h epc=%h mis=%b hlt=%b, want pc=%h vld=%b p4=%h epc=%h mis=%b hlt=%b",
                         name, i, g.pc, g.vld, g.p4, g.epc, g.mis, g.hlt, e.pc, e.vld, e.p4, e.epc, e.mis, e.hlt);
            end
        end
    endtask

    task automatic test_sequential();
        stim_t st[$];
        st.push_back(s_none()); exp_q.push_back(mk(32'h10074, 32'h0, 1'b1, 1'b0, 1'b0));
        st.push_back(s_none()); exp_q.push_back(mk(32'h10078, 32'h0, 1'b1, 1'b0, 1'b0));
        st.push_back(s_none()); exp_q.push_back(mk(32'h1007C, 32'h0, 1'b1, 1'b0, 1'b0));
        st.push_back(s_none()); exp_q.push_back(mk(32'h10080, 32'h0, 1'b1, 1'b0, 1'b0));
        run_steps("sequential", st);
    endtask

    task automatic test_branch_jump();
        stim_t st[$];
        st.push_back(s_br(32'hFFFF_FFF8, 1'b1)); exp_q.push_back(mk(32'h10078, 32'h0, 1'b1, 1'b0, 1'b0));
        st.push_back(s_jump(32'h10080));        exp_q.push_back(mk(32'h10080, 32'h0, 1'b1, 1'b0, 1'b0));
        st.push_back(s_br(32'hFFFF_FFF8, 1'b0)); exp_q.push_back(mk(32'h10084, 32'h0, 1'b1, 1'b0, 1'b0));
        st.push_back(s_jump(32'h2000));          exp_q.push_back(mk(32'h2000, 32'h0, 1'b1, 1'b0, 1'b0));
        run_steps("branch_jump", st);
    endtask

    task automatic test_stall();
        stim_t st[$];
        stim_t s;
        for (int i = 0; i < 2; i++) begin
            s = s_jump(32'h3000); s.stall = 1'b1;
            st.push_back(s); exp_q.push_back(mk(32'h2000, 32'h0, 1'b1, 1'b0, 1'b0));
        end
        for (int i = 0; i < 2; i++) begin
            s = s_jump(32'h3000); s.rdy = 1'b0;
            st.push_back(s); exp_q.push_back(mk(32'h2000, 32'h0, 1'b1, 1'b0, 1'b0));
        end
        st.push_back(s_jump(32'h3000)); exp_q.push_back(mk(32'h3000, 32'h0, 1'b1, 1'b0, 1'b0));
        st.push_back(s_jump(32'h2000)); exp_q.push_back(mk(32'h2000, 32'h0, 1'b1, 1'b0, 1'b0));
        run_steps("stall", st);
    endtask

    task automatic test_trap();
        stim_t st[$];
        stim_t s;
        s = s_jump(32'h4000); s.stall = 1'b1; s.trap = 1'b1;
        st.push_back(s);        exp_q.push_back(mk(32'h100, 32'h2000, 1'b1, 1'b0, 1'b0));
        st.push_back(s_none()); exp_q.push_back(mk(32'h104, 32'h2000, 1'b1, 1'b0, 1'b0));
        st.push_back(s_none()); exp_q.push_back(mk(32'h108, 32'h2000, 1'b1, 1'b0, 1'b0));
        s = s_none(); s.mret = 1'b1;
        st.push_back(s);        exp_q.push_back(mk(32'h2000, 32'h2000, 1'b1, 1'b0, 1'b0));
        st.push_back(s_none()); exp_q.push_back(mk(32'h2004, 32'h2000, 1'b1, 1'b0, 1'b0));
        s = s_none(); s.trap = 1'b1; s.mret = 1'b1;
        st.push_back(s);        exp_q.push_back(mk(32'h100, 32'h2004, 1'b1, 1'b0, 1'b0));
        s = s_none(); s.mret = 1'b1; s.stall = 1'b1; s.rdy = 1'b0;
        st.push_back(s);        exp_q.push_back(mk(32'h2004, 32'h2004, 1'b1, 1'b0, 1'b0));
        run_steps("trap", st);
    endtask

    task automatic test_misalign();
        stim_t st[$];
        st.push_back(s_jump(32'h2002));
`ifdef TOOTHLESS_MISALIGN_TRAP_EN
        exp_q.push_back(mk(32'h100, 32'h2002, 1'b1, 1'b0, 1'b1));
        st.push_back(s_none()); exp_q.push_back(mk(32'h104, 32'h2002, 1'b1, 1'b0, 1'b0));
        st.push_back(s_br(32'h1, 1'b1)); exp_q.push_back(mk(32'h100, 32'h105, 1'b1, 1'b0, 1'b1));
        st.push_back(s_none()); exp_q.push_back(mk(32'h104, 32'h105, 1'b1, 1'b0, 1'b0));
        cur_epc = 32'h105;
`else
        exp_q.push_back(mk(32'h2000, 32'h2004, 1'b1, 1'b0, 1'b1));
        st.push_back(s_none()); exp_q.push_back(mk(32'h2004, 32'h2004, 1'b1, 1'b0, 1'b0));
        st.push_back(s_br(32'h1, 1'b1)); exp_q.push_back(mk(32'h2004, 32'h2004, 1'b1, 1'b0, 1'b1));
        st.push_back(s_none()); exp_q.push_back(mk(32'h2008, 32'h2004, 1'b1, 1'b0, 1'b0));
        cur_epc = 32'h2004;
`endif
        run_steps("misalign", st);
    endtask

    task automatic test_wrap();
        stim_t st[$];
        st.push_back(s_jump(32'hFFFF_FFFC)); exp_q.push_back(mk(32'hFFFF_FFFC, cur_epc, 1'b1, 1'b0, 1'b0));
        st.push_back(s_none());              exp_q.push_back(mk(32'h0, cur_epc, 1'b1, 1'b0, 1'b0));
        run_steps("wrap", st);
    endtask

    task automatic test_halt();
        stim_t st[$];
        stim_t s;
        s = s_none(); s.halt = 1'b1;
        st.push_back(s); exp_q.push_back(mk(32'h4, cur_epc, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) begin
            s = (i == 2) ? s_jump(32'h5000) : s_none();
            s.trap = (i == 3);
            st.push_back(s); exp_q.push_back(mk(32'h4, cur_epc, 1'b0, 1'b1, 1'b0));
        end
        s = s_none(); s.resume = 1'b1;
        st.push_back(s);        exp_q.push_back(mk(32'h4, cur_epc, 1'b1, 1'b0, 1'b0));
        st.push_back(s_none()); exp_q.push_back(mk(32'h8, cur_epc, 1'b1, 1'b0, 1'b0));
        st.push_back(s_none()); exp_q.push_back(mk(32'hC, cur_epc, 1'b1, 1'b0, 1'b0));
        s = s_none(); s.halt = 1'b1; s.trap = 1'b1;
        st.push_back(s);        exp_q.push_back(mk(32'h100, 32'hC, 1'b1, 1'b0, 1'b0));
        st.push_back(s_none()); exp_q.push_back(mk(32'h104, 32'hC, 1'b1, 1'b0, 1'b0));
        run_steps("halt", st);
    endtask

    task automatic test_reset_midop();
        stim_t st[$];
        stim_t s;
        obs_t  g, e;
        s = s_jump(32'h6000); s.trap = 1'b1;
        rst_n = 1'b0;
        exp_q.push_back(mk(32'h10074, 32'h0, 1'b0, 1'b0, 1'b0));
        apply(s);
        g = sample();
        e = exp_q.pop_front();
        n_assert++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL reset_midop: got pc=%h vld=%b p4=%h epc=%h mis=%b hlt=%b, want pc=%h vld=%b p4=%h epc=%h mis=%b hlt=%b",
                     g.pc, g.vld, g.p4, g.epc, g.mis, g.hlt, e.pc, e.vld, e.p4, e.epc, e.mis, e.hlt);
        end
        rst_n = 1'b1;
        st.push_back(s_none()); exp_q.push_back(mk(32'h10074, 32'h0, 1'b1, 1'b0, 1'b0));
        st.push_back(s_none()); exp_q.push_back(mk(32'h10078, 32'h0, 1'b1, 1'b0, 1'b0));
        run_steps("after_reset", st);
    endtask

    initial begin
        rst_n             = 1'b0;
        ctrl_trans_instr  = CTRL_TRANS_SEL_NONE;
        offset            = '0;
        branch_tkn        = 1'b0;
        tgt_addr          = '0;
        stall             = 1'b0;
        fif.fetch_ready_i = 1'b1;
        trap              = 1'b0;
        mret              = 1'b0;
        halt              = 1'b0;
        resume            = 1'b0;
        cur_epc           = '0;

        test_reset();
        test_sequential();
        test_branch_jump();
        test_stall();
        test_trap();
        test_misalign();
        test_wrap();
        test_halt();
        test_reset_midop();

        if (exp_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter unit for the toothless core.
- Sequences the fetch address through sequential, jump, branch, trap and trap-return paths.
- Adds a fetch valid/ready handshake, a pipeline stall, a halt/resume state machine, and a saved exception PC (EPC).
- Sits between the decoder/ALU and the instruction-memory fetch port; drives the link address back to the RD write-back mux.

Parameters:
ADDR_WIDTH, 32, width of all address/PC signals
RESET_ADDR, 'h10074, PC value loaded on reset (start of .text)
TRAP_VEC, 'h00000100, PC loaded on trap entry
INSTR_BYTES, 4, sequential increment in bytes

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ctrl_trans_instr_i  in  2  CTRL_TRANS_SEL_{NONE,JUMP,BRANCH}; 2'b11 treated as NONE
offset_i  in  ADDR_WIDTH  branch offset relative to current PC, from decoder
branch_tkn_i  in  1  branch comparison result, from ALU
tgt_addr_i  in  ADDR_WIDTH  jump target, from ALU
stall_i  in  1  pipeline stall; hold PC
fetch_ready_i  in  1  fetch port accepts pc_o this cycle
trap_i  in  1  exception/interrupt request
mret_i  in  1  return from trap
halt_i  in  1  request halt (debug)
resume_i  in  1  leave halt
pc_o  out  ADDR_WIDTH  current fetch address
pc_valid_o  out  1  pc_o valid for fetch
pc_plus4_o  out  ADDR_WIDTH  pc_o + INSTR_BYTES, link address for JAL/JALR
epc_o  out  ADDR_WIDTH  saved exception PC
misaligned_o  out  1  one-cycle pulse: redirect target not INSTR_BYTES-aligned
halted_o  out  1  unit is in HALT state

Behaviour:
- Reset (rst_n low at posedge):
  - pc_o = RESET_ADDR, epc_o = 0, misaligned_o = 0, halted_o = 0, pc_valid_o = 0.
  - FSM enters BOOT.
- FSM states: BOOT, RUN, HALT.
  - BOOT -> RUN after exactly one cycle; pc_valid_o = 0 in BOOT.
  - RUN: pc_valid_o = 1.
  - RUN -> HALT when halt_i = 1 and no trap_i in the same cycle. The PC update of that cycle still happens, so the halted PC is the next PC.
  - HALT: pc_valid_o = 0, halted_o = 1, PC frozen.
  - HALT -> RUN on resume_i; pc_valid_o = 1 the cycle after resume_i.
  - trap_i in HALT is ignored.
- Advance condition in RUN: adv = !stall_i && fetch_ready_i.
- Next-PC priority, evaluated every RUN cycle:
  1. trap_i: pc_o <= TRAP_VEC, epc_o <= pc_o. Taken regardless of stall_i and fetch_ready_i.
  2. mret_i: pc_o <= epc_o. Regardless of stall_i and fetch_ready_i.
  3. !adv: pc_o holds. ctrl_trans_instr_i is ignored; the decoder re-presents it.
  4. JUMP: pc_o <= tgt_addr_i.
  5. BRANCH and branch_tkn_i: pc_o <= pc_o + offset_i.
  6. Otherwise (NONE, not-taken BRANCH, 2'b11): pc_o <= pc_o + INSTR_BYTES.
- trap_i and mret_i in the same cycle: trap wins; epc_o takes the current pc_o.
- Arithmetic: modulo 2^ADDR_WIDTH, wrap-around silent; no carry or overflow flag.
- pc_plus4_o is combinational from pc_o.
- Misaligned redirect target (JUMP, or taken BRANCH, with low log2(INSTR_BYTES) bits nonzero):
  - misaligned_o = 1 for one cycle, registered alongside the PC update.
  - Handling depends on MISALIGN_TRAP_EN.
- Reset mid-operation: overrides everything, including an in-flight trap; epc_o is cleared.

Optional Feature:
- Macro: TOOTHLESS_MISALIGN_TRAP_EN.
- Defined: a misaligned redirect is converted into a trap. pc_o <= TRAP_VEC, epc_o <= the faulting target address, misaligned_o pulses.
- Undefined:
  - The target's low alignment bits are forced to zero and taken as the next PC.
  - misaligned_o still pulses.
  - epc_o is unchanged.

Decomposition:
- toothless_pkg holds:
  - the existing CTRL_TRANS_SEL_* constants;
  - new pc_state_e enum {PC_BOOT, PC_RUN, PC_HALT};
  - default RESET_ADDR and TRAP_VEC localparams.
- One natural sub-module: pc_next_calc. Purely combinational; computes the target, misaligned flag and selected next PC from the priority list.
- pc_gen keeps the FSM, PC, EPC and output registers.

Test Plan:
- Reset then 3 NONE cycles with fetch_ready_i = 1:
  - pc_valid_o 0 in BOOT;
  - then pc_o = 'h10074, 'h10078, 'h1007C;
  - pc_plus4_o = pc_o + 4 each cycle.
- At pc_o = 'h10080:
  - BRANCH, offset_i = -8, branch_tkn_i = 1 -> pc_o = 'h10078;
  - same with branch_tkn_i = 0 -> 'h10084;
  - JUMP with tgt 'h2000 -> 'h2000.
- stall_i = 1 for 2 cycles with JUMP presented -> pc_o holds both cycles. Same with fetch_ready_i = 0. Release -> jump taken.
- trap_i with stall_i = 1 at pc_o = 'h2000 -> pc_o = 'h100, epc_o = 'h2000. mret_i 3 cycles later -> pc_o = 'h2000. trap_i and mret_i together -> trap taken.
- JUMP to 'h2002:
  - macro defined -> pc_o = 'h100, epc_o = 'h2002, misaligned_o pulse;
  - macro undefined -> pc_o = 'h2000, pulse.
- pc_o = 'hFFFFFFFC with NONE -> pc_o = 0. halt_i -> halted_o = 1, pc_valid_o = 0, PC frozen for 5 cycles. resume_i -> counting continues.
